// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers and defaults for the sync FIFO family.
// Also used by sync_fifo and its RAM wrapper.
package sync_fifo_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 16;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Encoded as {rd, wr} so the accept strobes cast straight in.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer with synchronous flush.
// Wraps explicitly, so non-power-of-two depths are fine.
module fifo_ptr_wrap
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Occupancy-counter FIFO controller: RAM addressing, flags,
// sticky errors, flush and peak-occupancy watermark.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH = addr_w(FIFO_DEPTH),
  parameter int CNT_WIDTH  = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid_s,
  input  logic                  i_ready_m,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_ready_s,
  output logic                  o_valid_m,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic [CNT_WIDTH-1:0]  o_peak,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic wr;
  logic rd;
  op_e  op;

  logic [CNT_WIDTH-1:0] count_q, count_d, count_nxt;
  logic [CNT_WIDTH-1:0] peak_q, peak_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Full with both requests rejects the write: no pass-through.
  assign wr = i_valid_s & ~full_q;
  assign rd = i_ready_m & ~empty_q;

  always_comb begin
    op        = op_e'({rd, wr});
    count_nxt = count_q;
    unique case (op)
      OP_WR:   count_nxt = count_q + ONE;
      OP_RD:   count_nxt = count_q - ONE;
      default: count_nxt = count_q;
    endcase

    count_d = i_flush ? '0 : count_nxt;

    // Flags come from the next count, so they are exact next cycle.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= i_almostfull_lvl);
    ae_d    = (count_d <= i_almostempty_lvl);

    peak_d = peak_q;
    if (i_clr_err) begin
      peak_d = count_d;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end

    ovf_d = i_clr_err ? 1'b0 : (ovf_q | (i_valid_s & full_q));
    unf_d = i_clr_err ? 1'b0 : (unf_q | (i_ready_m & empty_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      peak_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .flush (i_flush),
    .inc   (wr),
    .ptr   (o_wr_addr)
  );

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .flush (i_flush),
    .inc   (rd),
    .ptr   (o_rd_addr)
  );

  assign o_wr_en       = wr;
  assign o_rd_en       = rd;
  assign o_full        = full_q;
  assign o_empty       = empty_q;
  assign o_ready_s     = ~full_q;
  assign o_valid_m     = ~empty_q;
  assign o_almostfull  = af_q;
  assign o_almostempty = ae_q;
  assign o_count       = count_q;
  assign o_peak        = peak_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: depth 5 and depth 16 side by side,
// behavioural model plus read-address scoreboard.
`define CHK(k, tag, obs, exp) \
  begin \
    n_chk++; \
    assert ((obs) === (exp)) n_pass++; \
    else $error("FAIL %s[%0d]: got %0d want %0d", tag, k, obs, exp); \
  end

module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, vld, rdy, flush, clr;
  logic [2:0] afl0, ael0;
  logic [4:0] afl1, ael1;

  logic       d0_we, d0_re, d0_rs, d0_vm, d0_full, d0_empty;
  logic       d0_af, d0_ae, d0_ovf, d0_unf;
  logic [2:0] d0_wa, d0_ra, d0_cnt, d0_pk;
  logic       d1_we, d1_re, d1_rs, d1_vm, d1_full, d1_empty;
  logic       d1_af, d1_ae, d1_ovf, d1_unf;
  logic [3:0] d1_wa, d1_ra;
  logic [4:0] d1_cnt, d1_pk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  sync_fifo_ctrl #(.FIFO_DEPTH(5)) dut0 (
    .clk(clk), .reset(reset), .i_valid_s(vld), .i_ready_m(rdy),
    .i_flush(flush), .i_clr_err(clr),
    .i_almostfull_lvl(afl0), .i_almostempty_lvl(ael0),
    .o_wr_en(d0_we), .o_wr_addr(d0_wa), .o_rd_en(d0_re),
    .o_rd_addr(d0_ra), .o_ready_s(d0_rs), .o_valid_m(d0_vm),
    .o_full(d0_full), .o_empty(d0_empty), .o_almostfull(d0_af),
    .o_almostempty(d0_ae), .o_count(d0_cnt), .o_peak(d0_pk),
    .o_overflow(d0_ovf), .o_underflow(d0_unf)
  );

  sync_fifo_ctrl #(.FIFO_DEPTH(16)) dut1 (
    .clk(clk), .reset(reset), .i_valid_s(vld), .i_ready_m(rdy),
    .i_flush(flush), .i_clr_err(clr),
    .i_almostfull_lvl(afl1), .i_almostempty_lvl(ael1),
    .o_wr_en(d1_we), .o_wr_addr(d1_wa), .o_rd_en(d1_re),
    .o_rd_addr(d1_ra), .o_ready_s(d1_rs), .o_valid_m(d1_vm),
    .o_full(d1_full), .o_empty(d1_empty), .o_almostfull(d1_af),
    .o_almostempty(d1_ae), .o_count(d1_cnt), .o_peak(d1_pk),
    .o_overflow(d1_ovf), .o_underflow(d1_unf)
  );

  typedef struct {
    logic we, re, rs, vm, full, empty, af, ae, ovf, unf;
    logic [31:0] wa, ra, cnt, pk;
  } obs_t;

  typedef struct {
    int cnt, wp, rp, pk;
    bit ovf, unf, full, empty, af, ae;
  } mdl_t;

  obs_t ob[2];
  mdl_t m[2];
  int sb0[$];
  int sb1[$];

  always_comb begin
    ob[0].we = d0_we;  ob[0].re = d0_re;
    ob[0].rs = d0_rs;  ob[0].vm = d0_vm;
    ob[0].full = d0_full;  ob[0].empty = d0_empty;
    ob[0].af = d0_af;  ob[0].ae = d0_ae;
    ob[0].ovf = d0_ovf;  ob[0].unf = d0_unf;
    ob[0].wa = 32'(d0_wa);  ob[0].ra = 32'(d0_ra);
    ob[0].cnt = 32'(d0_cnt);  ob[0].pk = 32'(d0_pk);
    ob[1].we = d1_we;  ob[1].re = d1_re;
    ob[1].rs = d1_rs;  ob[1].vm = d1_vm;
    ob[1].full = d1_full;  ob[1].empty = d1_empty;
    ob[1].af = d1_af;  ob[1].ae = d1_ae;
    ob[1].ovf = d1_ovf;  ob[1].unf = d1_unf;
    ob[1].wa = 32'(d1_wa);  ob[1].ra = 32'(d1_ra);
    ob[1].cnt = 32'(d1_cnt);  ob[1].pk = 32'(d1_pk);
  end

  function automatic int dep(int k);
    return (k == 0) ? 5 : 16;
  endfunction

  function automatic int lvl_af(int k);
    return (k == 0) ? int'(afl0) : int'(afl1);
  endfunction

  function automatic int lvl_ae(int k);
    return (k == 0) ? int'(ael0) : int'(ael1);
  endfunction

  function automatic void sb_clear(int k);
    if (k == 0) sb0.delete();
    else sb1.delete();
  endfunction

  task automatic check_model(int k);
    bit wr, rd;
    int exp_ra, depth;
    wr = vld && !m[k].full;
    rd = rdy && !m[k].empty;
    `CHK(k, "wr_en", ob[k].we, wr)
    `CHK(k, "rd_en", ob[k].re, rd)
    `CHK(k, "wr_addr", ob[k].wa, m[k].wp)
    `CHK(k, "rd_addr", ob[k].ra, m[k].rp)
    `CHK(k, "count", ob[k].cnt, m[k].cnt)
    `CHK(k, "peak", ob[k].pk, m[k].pk)
    `CHK(k, "full", ob[k].full, m[k].full)
    `CHK(k, "empty", ob[k].empty, m[k].empty)
    `CHK(k, "ready_s", ob[k].rs, !m[k].full)
    `CHK(k, "valid_m", ob[k].vm, !m[k].empty)
    `CHK(k, "almostfull", ob[k].af, m[k].af)
    `CHK(k, "almostempty", ob[k].ae, m[k].ae)
    `CHK(k, "overflow", ob[k].ovf, m[k].ovf)
    `CHK(k, "underflow", ob[k].unf, m[k].unf)
    if (rd) begin
      depth = (k == 0) ? sb0.size() : sb1.size();
      `CHK(k, "sb_nonempty", depth > 0, 1'b1)
      if (depth > 0) begin
        exp_ra = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        `CHK(k, "sb_rd_addr", ob[k].ra, exp_ra)
      end
    end
    if (wr) begin
      if (k == 0) sb0.push_back(m[k].wp);
      else sb1.push_back(m[k].wp);
    end
  endtask

  function automatic void step(int k);
    bit wr, rd;
    int nxt, d;
    d = dep(k);
    if (reset) begin
      m[k] = '{default: 0};
      m[k].empty = 1;
      m[k].ae = 1;
      sb_clear(k);
      return;
    end
    wr = vld && !m[k].full;
    rd = rdy && !m[k].empty;
    nxt = flush ? 0 : m[k].cnt + int'(wr) - int'(rd);
    if (flush) begin
      m[k].wp = 0;
      m[k].rp = 0;
      sb_clear(k);
    end else begin
      if (wr) m[k].wp = (m[k].wp == d - 1) ? 0 : m[k].wp + 1;
      if (rd) m[k].rp = (m[k].rp == d - 1) ? 0 : m[k].rp + 1;
    end
    m[k].ovf = clr ? 1'b0 : (m[k].ovf || (vld && m[k].full));
    m[k].unf = clr ? 1'b0 : (m[k].unf || (rdy && m[k].empty));
    m[k].pk = clr ? nxt : ((nxt > m[k].pk) ? nxt : m[k].pk);
    m[k].cnt = nxt;
    m[k].full = (nxt == d);
    m[k].empty = (nxt == 0);
    m[k].af = (nxt >= lvl_af(k));
    m[k].ae = (nxt <= lvl_ae(k));
  endfunction

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk_en) begin
        check_model(0);
        check_model(1);
      end
      step(0);
      step(1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(bit v, bit r, bit f, bit c);
    vld = v;
    rdy = r;
    flush = f;
    clr = c;
  endtask

  task automatic rchk(int k, string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $error("RESET FAIL %s[%0d]: got %0d want %0d",
                tag, k, obs, exp);
  endtask

  task automatic chk_reset_state(int k);
    rchk(k, "rst_count", ob[k].cnt, 0);
    rchk(k, "rst_peak", ob[k].pk, 0);
    rchk(k, "rst_empty", ob[k].empty, 1);
    rchk(k, "rst_almostempty", ob[k].ae, 1);
    rchk(k, "rst_valid_m", ob[k].vm, 0);
    rchk(k, "rst_full", ob[k].full, 0);
    rchk(k, "rst_almostfull", ob[k].af, 0);
    rchk(k, "rst_ready_s", ob[k].rs, 1);
    rchk(k, "rst_overflow", ob[k].ovf, 0);
    rchk(k, "rst_underflow", ob[k].unf, 0);
    rchk(k, "rst_wr_addr", ob[k].wa, 0);
    rchk(k, "rst_rd_addr", ob[k].ra, 0);
  endtask

  task automatic wait_flag_full0(int lim);
    int i;
    i = 0;
    while (ob[0].full !== 1'b1 && i < lim) begin
      tick();
      i++;
    end
    n_chk++;
    if (ob[0].full === 1'b1) n_pass++;
    else $error("WAIT FAIL full[0] expired after %0d cycles", lim);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    afl0 = 3'd4;
    ael0 = 3'd1;
    afl1 = 5'd12;
    ael1 = 5'd3;
    tick(2);
    chk_reset_state(0);
    chk_reset_state(1);
    reset = 1'b0;
    chk_en = 1;

    drive(1, 0, 0, 0);
    tick(6);
    wait_flag_full0(8);
    `CHK(0, "fill_full", ob[0].full, 1'b1)
    `CHK(0, "fill_count", ob[0].cnt, 5)
    `CHK(0, "fill_overflow", ob[0].ovf, 1'b1)
    `CHK(0, "fill_peak", ob[0].pk, 5)
    `CHK(1, "fill_count", ob[1].cnt, 6)

    drive(0, 1, 0, 0);
    tick(6);
    `CHK(0, "drain_empty", ob[0].empty, 1'b1)
    `CHK(0, "drain_underflow", ob[0].unf, 1'b1)
    `CHK(0, "drain_rd_wrap", ob[0].ra, 0)
    `CHK(1, "drain_underflow", ob[1].unf, 1'b0)
    drive(0, 0, 0, 1);
    tick();
    `CHK(0, "clr_underflow", ob[0].unf, 1'b0)
    `CHK(0, "clr_overflow", ob[0].ovf, 1'b0)
    `CHK(0, "clr_peak", ob[0].pk, 0)

    drive(0, 0, 0, 0);
    afl1 = 5'd0;
    tick();
    `CHK(1, "af_lvl0", ob[1].af, 1'b1)
    afl1 = 5'd12;
    tick();
    `CHK(1, "af_lvl12_empty", ob[1].af, 1'b0)

    drive(1, 0, 0, 0);
    tick(11);
    `CHK(1, "ramp_af_at11", ob[1].af, 1'b0)
    tick();
    `CHK(1, "ramp_af_at12", ob[1].af, 1'b1)
    tick(4);
    `CHK(1, "ramp_full", ob[1].full, 1'b1)
    `CHK(1, "ramp_ae", ob[1].ae, 1'b0)
    drive(0, 1, 0, 0);
    tick(12);
    `CHK(1, "ramp_ae_at4", ob[1].ae, 1'b0)
    tick();
    `CHK(1, "ramp_ae_at3", ob[1].ae, 1'b1)
    tick(3);
    `CHK(1, "ramp_empty", ob[1].empty, 1'b1)

    drive(1, 0, 0, 0);
    tick(8);
    drive(1, 1, 0, 0);
    tick(20);
    `CHK(1, "steady_count", ob[1].cnt, 8)
    `CHK(1, "steady_af", ob[1].af, 1'b0)
    drive(1, 0, 0, 0);
    tick(8);
    `CHK(1, "full16_count", ob[1].cnt, 16)
    drive(1, 1, 0, 0);
    tick();
    `CHK(1, "full_rw_count", ob[1].cnt, 15)
    drive(0, 0, 1, 1);
    tick();
    `CHK(1, "flush_clr_peak", ob[1].pk, 0)
    drive(1, 1, 0, 0);
    tick();
    `CHK(1, "empty_rw_count", ob[1].cnt, 1)
    `CHK(0, "empty_rw_count", ob[0].cnt, 1)

    drive(1, 0, 0, 0);
    tick(9);
    `CHK(1, "pre_flush_count", ob[1].cnt, 10)
    drive(1, 0, 1, 0);
    tick();
    `CHK(1, "flush_count", ob[1].cnt, 0)
    `CHK(1, "flush_empty", ob[1].empty, 1'b1)
    `CHK(1, "flush_ae", ob[1].ae, 1'b1)
    `CHK(1, "flush_wr_addr", ob[1].wa, 0)
    `CHK(1, "flush_rd_addr", ob[1].ra, 0)
    `CHK(1, "flush_peak", ob[1].pk, 10)
    `CHK(0, "flush_peak", ob[0].pk, 5)

    drive(1, 0, 0, 0);
    tick(7);
    `CHK(1, "pre_rst_count", ob[1].cnt, 7)
    `CHK(0, "pre_rst_overflow", ob[0].ovf, 1'b1)
    reset = 1'b1;
    tick();
    chk_reset_state(0);
    chk_reset_state(1);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
